axis_bram_loader: RTL
=====================

Name: axis_bram_loader

Overview:
- Upstream stage of the BRAM summation engine: accepts one frame of 32-bit words from the DMA MM2S AXI-Stream and writes it into BRAM port A at addresses 0..DEPTH-1.
- Zero-pads short frames and discards the excess of long frames.
- Drives the summer's start/done handshake, captures the final sum, and presents it to the host via a valid/ready result interface.
- Then re-arms for the next frame.

Parameters:
- DEPTH, 1024, BRAM words per frame; summer sweeps exactly this many addresses.
- ADDR_W, 12, BRAM address width; DEPTH <= 2^ADDR_W.
- DATA_W, 32, stream/BRAM/sum data width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_axis_tdata  in  DATA_W  stream data from DMA
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- s_axis_tlast  in  1  last beat of frame
- bram_we  out  1  BRAM port A write enable
- bram_addr  out  ADDR_W  BRAM port A address
- bram_din  out  DATA_W  BRAM port A write data
- sum_start  out  1  level start to summer; summer clears itself while low
- sum_done  in  1  summer done (high when idle or finished, low while summing)
- sum_in  in  DATA_W  summer accumulated sum
- result  out  DATA_W  captured frame sum
- result_valid  out  1  result available
- result_ready  in  1  host accepts result
- frame_len  out  ADDR_W+1  real words received in last frame (1..DEPTH)
- overflow  out  1  sticky: a frame exceeded DEPTH words

Behaviour:
- Reset (reset=1 at posedge clk): state=FILL, wr_ptr=0, s_axis_tready=0 for that cycle, sum_start=0, result=0, result_valid=0, frame_len=0, overflow=0. Reset mid-operation aborts everything; summer clears because sum_start drops.
- State FILL:
  - s_axis_tready=1.
  - bram_we = tvalid & tready (combinational), bram_addr=wr_ptr, bram_din=tdata; zero latency from beat to write.
  - Each beat: wr_ptr++.
  - Beat with tlast and wr_ptr<DEPTH-1: frame_len<=wr_ptr+1 -> PAD.
  - Beat with wr_ptr==DEPTH-1 and tlast: frame_len<=DEPTH -> ARM.
  - Beat with wr_ptr==DEPTH-1 and no tlast: frame_len<=DEPTH, overflow<=1 -> DRAIN.
- State PAD:
  - s_axis_tready=0, bram_we=1, bram_din=0, bram_addr=wr_ptr; one zero word per cycle.
  - wr_ptr==DEPTH-1 written -> ARM.
- State DRAIN:
  - s_axis_tready=1, bram_we=0; beats are discarded.
  - Beat with tlast -> ARM.
- State ARM:
  - sum_start=1, tready=0.
  - Wait for sum_done==0, which appears 2 cycles after start rises -> RUN.
  - Never samples sum_done==1 as completion while in ARM.
- State RUN:
  - sum_start=1.
  - On sum_done==1: result<=sum_in, result_valid<=1 -> HOLD.
  - sum_in is stable when sum_done is high.
- State HOLD:
  - sum_start=0, result_valid=1, tready=0.
  - On result_valid & result_ready: result_valid<=0, wr_ptr<=0 -> FILL.
  - result, frame_len and overflow hold their values until overwritten by the next frame.
- Arithmetic/width rules:
  - wr_ptr is ADDR_W bits and never exceeds DEPTH-1.
  - bram_addr is zero when not writing.
  - result is the summer's modulo-2^DATA_W value, passed through unchanged.
- Boundary conditions:
  - tvalid while tready=0 (PAD/ARM/RUN/HOLD): no write; the DMA stalls.
  - Single-word frame (tlast on first beat): frame_len=1; addresses 1..DEPTH-1 are zero-padded.
  - overflow is cleared only by reset.
  - result_ready asserted outside HOLD is ignored.

Test Plan:
1. Frame of exactly 1024 beats, data=i (0..1023), tlast on beat 1023 -> 1024 writes at addr i; sum_start high; result=523776, result_valid=1, frame_len=1024, overflow=0.
2. Frame of 4 beats {5,6,7,8} with tlast on beat 4 -> addr 0..3 written, PAD writes 0 to addr 4..1023 (1020 cycles, tready=0); result=26, frame_len=4.
3. Frame of 1030 beats of 1 with tlast on beat 1030 -> only 1024 writes; last 6 beats accepted and discarded; overflow=1, frame_len=1024, result=1024.
4. tvalid toggling every other cycle during FILL, then result_ready held low 20 cycles in HOLD -> writes only on handshake cycles; result_valid and result stay stable until ready; next frame is not accepted until then.
5. Assert reset for 1 cycle while in RUN -> next cycle sum_start=0, state FILL, result_valid=0, overflow=0; following 1024-beat all-2 frame gives result=2048.
6. Back-to-back frames (A: all 1s, B: all 3s, ready tied high) -> results 1024 then 3072; tready is low from the last beat of A until HOLD exits.

Source files
------------

// File: rtl/axis_bram_loader.sv
// axis_bram_loader: takes one AXI-Stream frame from the DMA into BRAM port A
// (addresses 0..DEPTH-1). Short frames are zero-padded and the excess of long
// frames is drained. It then runs the summer through its start/done handshake
// and offers the captured sum to the host over a valid/ready pair.
//
// state | meaning
// FILL  | accepting beats, one BRAM write per handshake
// PAD   | frame ended early, writing zeros up to DEPTH-1
// DRAIN | DEPTH words stored, swallowing beats until tlast
// ARM   | sum_start high, waiting for the summer to drop done
// RUN   | summer busy, waiting for done to return high
// HOLD  | result_valid high until the host takes the sum
module axis_bram_loader #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic              s_axis_tlast,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_din,
   output logic              sum_start,
   input  logic              sum_done,
   input  logic [DATA_W-1:0] sum_in,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   input  logic              result_ready,
   output logic [ADDR_W:0]   frame_len,
   output logic              overflow
);

   typedef enum logic [2:0] {
      S_FILL  = 3'd0,
      S_PAD   = 3'd1,
      S_DRAIN = 3'd2,
      S_ARM   = 3'd3,
      S_RUN   = 3'd4,
      S_HOLD  = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   FULL_LEN  = (ADDR_W + 1)'(DEPTH);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                result_valid_q, result_valid_d;
   logic [ADDR_W:0]     frame_len_q, frame_len_d;
   logic                overflow_q, overflow_d;

   logic                tready_c;
   logic                we_c;
   logic [ADDR_W-1:0]   addr_c;
   logic [DATA_W-1:0]   din_c;
   logic                start_c;

   // Next-state and port-A/summer controls; everything is idle by default.
   always_comb begin
      state_d        = state_q;
      wr_ptr_d       = wr_ptr_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      frame_len_d    = frame_len_q;
      overflow_d     = overflow_q;
      tready_c       = 1'b0;
      we_c           = 1'b0;
      addr_c         = '0;
      din_c          = '0;
      start_c        = 1'b0;

      case (state_q)
         S_FILL: begin
            tready_c = 1'b1;
            if (s_axis_tvalid) begin
               we_c   = 1'b1;
               addr_c = wr_ptr_q;
               din_c  = s_axis_tdata;
               if (wr_ptr_q == LAST_ADDR) begin
                  // Pointer parks at the last address; HOLD rewinds it.
                  frame_len_d = FULL_LEN;
                  if (s_axis_tlast) begin
                     state_d = S_ARM;
                  end else begin
                     overflow_d = 1'b1;
                     state_d    = S_DRAIN;
                  end
               end else begin
                  wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                  if (s_axis_tlast) begin
                     frame_len_d = {1'b0, wr_ptr_q} + (ADDR_W + 1)'(1);
                     state_d     = S_PAD;
                  end
               end
            end
         end
         S_PAD: begin
            we_c   = 1'b1;
            addr_c = wr_ptr_q;
            if (wr_ptr_q == LAST_ADDR) begin
               state_d = S_ARM;
            end else begin
               wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
         end
         S_DRAIN: begin
            tready_c = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) begin
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            // done is still high from idle here; only its fall means started.
            start_c = 1'b1;
            if (!sum_done) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            start_c = 1'b1;
            if (sum_done) begin
               result_d       = sum_in;
               result_valid_d = 1'b1;
               state_d        = S_HOLD;
            end
         end
         S_HOLD: begin
            if (result_ready) begin
               result_valid_d = 1'b0;
               wr_ptr_d       = '0;
               state_d        = S_FILL;
            end
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   // Ports are forced idle during the reset cycle so nothing is written or started.
   always_comb begin
      s_axis_tready = tready_c & ~reset;
      bram_we       = we_c & ~reset;
      bram_addr     = bram_we ? addr_c : '0;
      bram_din      = bram_we ? din_c : '0;
      sum_start     = start_c & ~reset;
      result        = result_q;
      result_valid  = result_valid_q;
      frame_len     = frame_len_q;
      overflow      = overflow_q;
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_FILL;
         wr_ptr_q       <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         frame_len_q    <= '0;
         overflow_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         frame_len_q    <= frame_len_d;
         overflow_q     <= overflow_d;
      end
   end

endmodule
